// File: rtl/wb_cam_pkg.sv
// Shared definitions for the Wishbone camera capture block: register map,
// CTRL/STATUS bit positions, FSM encoding and the CTRL register layout.
package wb_cam_pkg;

    localparam int unsigned WORD_W       = 32;
    localparam int unsigned FRAME_CNT_W  = 16;
    localparam int unsigned STAT_LEVEL_W = 9;

    // Word offsets (wb_adr_i[4:2])
    localparam logic [2:0] ADR_CTRL      = 3'd0;
    localparam logic [2:0] ADR_STATUS    = 3'd1;
    localparam logic [2:0] ADR_DATA      = 3'd2;
    localparam logic [2:0] ADR_FRAME_CNT = 3'd3;
    localparam logic [2:0] ADR_STATE     = 3'd4;

    localparam int unsigned CTRL_ENABLE = 0;
    localparam int unsigned CTRL_SINGLE = 1;
    localparam int unsigned CTRL_FLUSH  = 2;
    localparam int unsigned CTRL_IRQ_EN = 3;

    localparam int unsigned STAT_NOT_EMPTY  = 0;
    localparam int unsigned STAT_FULL       = 1;
    localparam int unsigned STAT_OVERFLOW   = 2;
    localparam int unsigned STAT_FRAME_DONE = 3;
    localparam int unsigned STAT_LEVEL_LSB  = 8;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_CAPTURE    = 2'd2
    } cam_state_e;

    typedef struct packed {
        logic irq_en;
        logic flush;
        logic single;
        logic enable;
    } ctrl_t;

endpackage

// File: rtl/cam_sync_fifo.sv
// Single-clock FIFO with flush; simultaneous push/pop always succeed, and an
// empty FIFO forwards the pushed word straight to the read port.
module cam_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_dat,
    output logic [WIDTH-1:0]           o_dat_c,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             r_full;
    logic             r_empty;

    logic             w_do_push;
    logic             w_do_pop;
    logic [LW-1:0]    w_level_nx;

    assign w_do_push = i_push & (~r_full | i_pop);
    assign w_do_pop  = i_pop & (~r_empty | i_push);

    always_comb begin
        w_level_nx = r_level;
        if (w_do_push & ~w_do_pop) begin
            w_level_nx = r_level + LW'(1);
        end else if (w_do_pop & ~w_do_push) begin
            w_level_nx = r_level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push & ~i_flush) begin
            r_mem[r_wr_ptr] <= i_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level <= w_level_nx;
            r_full  <= (w_level_nx == LW'(DEPTH));
            r_empty <= (w_level_nx == '0);
        end
    end

    assign o_dat_c = r_empty ? i_dat : r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_level = r_level;

endmodule

// File: rtl/wb_cam_capture.sv
// Camera capture engine: synchronises a parallel camera port, packs pixels
// into 32-bit words, buffers them in a FIFO and exposes it on Wishbone.
module wb_cam_capture
    import wb_cam_pkg::*;
#(
    parameter int unsigned PIX_W      = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_stb_i,
    input  logic             wb_cyc_i,
    input  logic             wb_we_i,
    input  logic [31:0]      wb_adr_i,
    input  logic [3:0]       wb_sel_i,
    input  logic [31:0]      wb_dat_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    output logic             irq,
    input  logic             vsync,
    input  logic             href,
    input  logic             pclk,
    input  logic [PIX_W-1:0] data
);
    localparam int unsigned PPW   = WORD_W / PIX_W;
    localparam int unsigned CNT_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]             r_rst_sync;
    logic                   w_rst_n;

    logic [1:0]             r_vsync_s;
    logic [1:0]             r_href_s;
    logic [1:0]             r_pclk_s;
    logic [PIX_W-1:0]       r_data_s1;
    logic [PIX_W-1:0]       r_data_s2;
    logic                   r_pclk_d;
    logic                   r_vsync_d;

    cam_state_e             r_state;
    cam_state_e             w_state_nx;
    logic                   w_capture;
    logic                   w_frame_end;

    logic [WORD_W-1:0]      r_word;
    logic [CNT_W-1:0]       r_pix_cnt;
    logic [WORD_W-1:0]      w_word_ins;
    logic                   r_push;
    logic [WORD_W-1:0]      r_push_dat;

    ctrl_t                  r_ctrl;
    logic                   r_overflow;
    logic                   r_frame_done;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic                   r_ack;
    logic [31:0]            r_dat;
    logic                   r_irq;

    logic                   w_req;
    logic                   w_wr;
    logic                   w_rd;
    logic [2:0]             w_adr;
    logic                   w_pop;
    logic                   w_pix_stb;
    logic                   w_vs_rise;
    logic                   w_vs_fall;
    logic                   w_ovf_set;
    logic [WORD_W-1:0]      w_fifo_dat;
    logic                   w_full;
    logic                   w_empty;
    logic [LVL_W-1:0]       w_level;
    logic [31:0]            w_status;
    logic [31:0]            w_rd_dat;
    logic                   w_unused;

    assign w_unused = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_sel_i, wb_dat_i[31:4]};

    // Reset asserts asynchronously, releases on a clk edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_vsync_s <= '0;
            r_href_s  <= '0;
            r_pclk_s  <= '0;
            r_data_s1 <= '0;
            r_data_s2 <= '0;
            r_pclk_d  <= 1'b0;
            r_vsync_d <= 1'b0;
        end else begin
            r_vsync_s <= {r_vsync_s[0], vsync};
            r_href_s  <= {r_href_s[0], href};
            r_pclk_s  <= {r_pclk_s[0], pclk};
            r_data_s1 <= data;
            r_data_s2 <= r_data_s1;
            r_pclk_d  <= r_pclk_s[1];
            r_vsync_d <= r_vsync_s[1];
        end
    end

    assign w_pix_stb = r_pclk_s[1] & ~r_pclk_d & r_href_s[1];
    assign w_vs_rise = r_vsync_s[1] & ~r_vsync_d;
    assign w_vs_fall = ~r_vsync_s[1] & r_vsync_d;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nx;
    end

    // Dropping enable overrides every transition
    always_comb begin
        w_state_nx  = r_state;
        w_capture   = 1'b0;
        w_frame_end = 1'b0;
        if (!r_ctrl.enable) begin
            w_state_nx = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:       w_state_nx = ST_WAIT_FRAME;
                ST_WAIT_FRAME: if (w_vs_fall) w_state_nx = ST_CAPTURE;
                ST_CAPTURE: begin
                    w_capture = 1'b1;
                    if (w_vs_rise) begin
                        w_frame_end = 1'b1;
                        w_state_nx  = r_ctrl.single ? ST_IDLE : ST_WAIT_FRAME;
                    end
                end
                default:       w_state_nx = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_word_ins = r_word;
        w_word_ins[32'(r_pix_cnt) * PIX_W +: PIX_W] = r_data_s2;
    end

    // Packer: leaving CAPTURE for any reason other than frame end discards
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_word     <= '0;
            r_pix_cnt  <= '0;
            r_push     <= 1'b0;
            r_push_dat <= '0;
        end else begin
            r_push <= 1'b0;
            if (r_ctrl.flush || !w_capture) begin
                r_word    <= '0;
                r_pix_cnt <= '0;
            end else if (w_frame_end) begin
                if (r_pix_cnt != '0) begin
                    r_push     <= 1'b1;
                    r_push_dat <= r_word;
                end
                r_word    <= '0;
                r_pix_cnt <= '0;
            end else if (w_pix_stb) begin
                if (r_pix_cnt == CNT_W'(PPW - 1)) begin
                    r_push     <= 1'b1;
                    r_push_dat <= w_word_ins;
                    r_word     <= '0;
                    r_pix_cnt  <= '0;
                end else begin
                    r_word    <= w_word_ins;
                    r_pix_cnt <= r_pix_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign w_req = wb_stb_i & wb_cyc_i & ~r_ack;
    assign w_wr  = w_req & wb_we_i;
    assign w_rd  = w_req & ~wb_we_i;
    assign w_adr = wb_adr_i[4:2];
    assign w_pop = w_rd & (w_adr == ADR_DATA) & ~w_empty;
    assign w_ovf_set = r_push & w_full & ~w_pop & ~r_ctrl.flush;

    cam_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (w_rst_n),
        .i_push  (r_push),
        .i_pop   (w_pop),
        .i_flush (r_ctrl.flush),
        .i_dat   (r_push_dat),
        .o_dat_c (w_fifo_dat),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    // Control/status registers; hardware set beats a same-cycle W1C
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ctrl       <= '0;
            r_overflow   <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            if (w_wr && w_adr == ADR_CTRL) begin
                r_ctrl.enable <= wb_dat_i[CTRL_ENABLE];
                r_ctrl.single <= wb_dat_i[CTRL_SINGLE];
                r_ctrl.flush  <= wb_dat_i[CTRL_FLUSH];
                r_ctrl.irq_en <= wb_dat_i[CTRL_IRQ_EN];
            end else begin
                r_ctrl.flush <= 1'b0;
            end
            if (w_frame_end && r_ctrl.single) r_ctrl.enable <= 1'b0;

            if (w_ovf_set) r_overflow <= 1'b1;
            else if (w_wr && w_adr == ADR_STATUS && wb_dat_i[STAT_OVERFLOW]) r_overflow <= 1'b0;

            if (w_frame_end) r_frame_done <= 1'b1;
            else if (w_wr && w_adr == ADR_STATUS && wb_dat_i[STAT_FRAME_DONE]) r_frame_done <= 1'b0;

            if (w_frame_end) r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
        end
    end

    always_comb begin
        w_status = '0;
        w_status[STAT_NOT_EMPTY]  = ~w_empty;
        w_status[STAT_FULL]       = w_full;
        w_status[STAT_OVERFLOW]   = r_overflow;
        w_status[STAT_FRAME_DONE] = r_frame_done;
        w_status[STAT_LEVEL_LSB +: STAT_LEVEL_W] = STAT_LEVEL_W'(w_level);
    end

    always_comb begin
        w_rd_dat = '0;
        case (w_adr)
            ADR_CTRL:      w_rd_dat = {28'd0, r_ctrl};
            ADR_STATUS:    w_rd_dat = w_status;
            ADR_DATA:      w_rd_dat = w_empty ? '0 : w_fifo_dat;
            ADR_FRAME_CNT: w_rd_dat = {16'd0, r_frame_cnt};
            ADR_STATE:     w_rd_dat = {30'd0, r_state};
            default:       w_rd_dat = '0;
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ack <= 1'b0;
            r_dat <= '0;
            r_irq <= 1'b0;
        end else begin
            r_ack <= w_req;
            r_dat <= w_rd ? w_rd_dat : '0;
            r_irq <= r_ctrl.irq_en & (r_frame_done | r_overflow);
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat;
    assign irq      = r_irq;

endmodule

// File: tb/tb_wb_cam_capture.sv
// Directed bench for wb_cam_capture: an 8-bit/depth-4 instance and a
// 16-bit instance share the bus and camera pins; sel16 picks whose reads count.
module tb_wb_cam_capture;

    logic        clk;
    logic        reset;
    logic        stb, cyc, we;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
    logic [31:0] dat8, dat16;
    logic        ack8, ack16, irq8, irq16;
    logic        vsync, href, pclk;
    logic [15:0] cam_data;
    logic        sel16;

    int n_cmp;
    int n_bad;

    typedef struct packed {
        logic [31:0] adr;
        logic        we;
        logic [31:0] wdat;
        logic [31:0] exp;
    } vec_t;

    vec_t tab [12];

    wb_cam_capture #(.PIX_W(8), .FIFO_DEPTH(4)) dut8 (
        .clk(clk), .reset(reset),
        .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(wdat),
        .wb_dat_o(dat8), .wb_ack_o(ack8), .irq(irq8),
        .vsync(vsync), .href(href), .pclk(pclk), .data(cam_data[7:0])
    );

    wb_cam_capture #(.PIX_W(16), .FIFO_DEPTH(16)) dut16 (
        .clk(clk), .reset(reset),
        .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(wdat),
        .wb_dat_o(dat16), .wb_ack_o(ack16), .irq(irq16),
        .vsync(vsync), .href(href), .pclk(pclk), .data(cam_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [31:0] a, input logic w,
                                input logic [31:0] d, input logic [31:0] e);
        return {a, w, d, e};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                           output logic [31:0] q);
        int t;
        @(posedge clk);
        #1;
        adr = a; we = w; wdat = d; stb = 1'b1; cyc = 1'b1;
        t = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (!(sel16 ? ack16 : ack8) && t < 8);
        check("wb_ack_latency", 32'(t), 32'd1);
        q = sel16 ? dat16 : dat8;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] q;
        wb_xfer(a, 1'b1, d, q);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] q;
        wb_xfer(a, 1'b0, 32'd0, q);
        check(name, q, exp);
    endtask

    task automatic run_table(input int first, input int last);
        logic [31:0] q;
        for (int i = first; i <= last; i++) begin
            if (tab[i].we) begin
                wr(tab[i].adr, tab[i].wdat);
            end else begin
                wb_xfer(tab[i].adr, 1'b0, 32'd0, q);
                check($sformatf("tab%0d_adr%02h", i, tab[i].adr[7:0]), q, tab[i].exp);
            end
        end
    endtask

    task automatic send_px(input logic [15:0] v);
        cam_data = v;
        pclk = 1'b0;
        wait_clk(4);
        pclk = 1'b1;
        wait_clk(4);
        pclk = 1'b0;
    endtask

    task automatic send_line(input int n, input logic [15:0] base);
        href = 1'b1;
        for (int k = 0; k < n; k++) send_px(base + 16'(k));
        href = 1'b0;
        wait_clk(8);
    endtask

    task automatic frame_start();
        vsync = 1'b1;
        wait_clk(8);
        vsync = 1'b0;
        wait_clk(8);
    endtask

    task automatic frame_end();
        href = 1'b0;
        wait_clk(8);
        vsync = 1'b1;
        wait_clk(8);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        reset = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0;
        adr = '0; wdat = '0; sel = 4'hF;
        vsync = 1'b1; href = 1'b0; pclk = 1'b0; cam_data = '0; sel16 = 1'b0;

        tab[0]  = mk(32'h00, 1'b0, 32'h0, 32'h0);
        tab[1]  = mk(32'h04, 1'b0, 32'h0, 32'h0);
        tab[2]  = mk(32'h08, 1'b0, 32'h0, 32'h0);
        tab[3]  = mk(32'h0C, 1'b0, 32'h0, 32'h0);
        tab[4]  = mk(32'h10, 1'b0, 32'h0, 32'h0);
        tab[5]  = mk(32'h1C, 1'b0, 32'h0, 32'h0);
        tab[6]  = mk(32'h14, 1'b1, 32'hFFFF_FFFF, 32'h0);
        tab[7]  = mk(32'h14, 1'b0, 32'h0, 32'h0);
        tab[8]  = mk(32'h00, 1'b1, 32'h8, 32'h0);
        tab[9]  = mk(32'h00, 1'b0, 32'h0, 32'h8);
        tab[10] = mk(32'h00, 1'b1, 32'h0, 32'h0);
        tab[11] = mk(32'h00, 1'b0, 32'h0, 32'h0);

        wait_clk(3);
        check("rst_ack", {31'd0, ack8}, 32'd0);
        check("rst_dat", dat8, 32'd0);
        check("rst_irq", {31'd0, irq8}, 32'd0);
        reset = 1'b1;
        wait_clk(5);
        run_table(0, 11);

        // 8-bit frame, 2 lines x 4 px
        wr(32'h00, 32'h1);
        frame_start();
        send_line(4, 16'h01);
        send_line(4, 16'h05);
        frame_end();
        rd_chk("f1_status", 32'h04, 32'h0000_0209);
        rd_chk("f1_frame_cnt", 32'h0C, 32'd1);
        rd_chk("f1_state", 32'h10, 32'd1);
        rd_chk("f1_data0", 32'h08, 32'h0403_0201);
        rd_chk("f1_data1", 32'h08, 32'h0807_0605);
        rd_chk("f1_status_after", 32'h04, 32'h0000_0008);
        wr(32'h04, 32'h8);
        rd_chk("f1_w1c", 32'h04, 32'h0);

        // 5-pixel frame: trailing partial word is zero-padded
        frame_start();
        send_line(5, 16'hA1);
        frame_end();
        rd_chk("f2_status", 32'h04, 32'h0000_0209);
        rd_chk("f2_data0", 32'h08, 32'hA4A3_A2A1);
        rd_chk("f2_data1", 32'h08, 32'h0000_00A5);
        rd_chk("f2_frame_cnt", 32'h0C, 32'd2);
        wr(32'h04, 32'h8);

        // 20 words into a depth-4 FIFO with no reads
        frame_start();
        send_line(80, 16'h00);
        frame_end();
        rd_chk("ovf_status", 32'h04, 32'h0000_040F);
        check("ovf_irq_masked", {31'd0, irq8}, 32'd0);
        wr(32'h00, 32'h9);
        wait_clk(2);
        check("ovf_irq_on", {31'd0, irq8}, 32'd1);
        rd_chk("ovf_data0", 32'h08, 32'h0302_0100);
        rd_chk("ovf_data1", 32'h08, 32'h0706_0504);
        rd_chk("ovf_data2", 32'h08, 32'h0B0A_0908);
        rd_chk("ovf_data3", 32'h08, 32'h0F0E_0D0C);
        rd_chk("ovf_empty_read", 32'h08, 32'h0);
        rd_chk("ovf_status_drained", 32'h04, 32'h0000_000C);
        wr(32'h04, 32'hC);
        wait_clk(2);
        rd_chk("ovf_w1c", 32'h04, 32'h0);
        check("ovf_irq_off", {31'd0, irq8}, 32'd0);
        rd_chk("ovf_frame_cnt", 32'h0C, 32'd3);

        // single-shot: second frame must be ignored
        wr(32'h00, 32'h3);
        frame_start();
        send_line(4, 16'h11);
        frame_end();
        frame_start();
        send_line(4, 16'h21);
        frame_end();
        rd_chk("single_data0", 32'h08, 32'h1413_1211);
        rd_chk("single_empty", 32'h08, 32'h0);
        rd_chk("single_ctrl", 32'h00, 32'h2);
        rd_chk("single_state", 32'h10, 32'd0);
        rd_chk("single_frame_cnt", 32'h0C, 32'd4);
        wr(32'h04, 32'h8);

        // flush drops buffered words and self-clears
        wr(32'h00, 32'h1);
        frame_start();
        send_line(8, 16'h31);
        frame_end();
        rd_chk("flush_pre_status", 32'h04, 32'h0000_0209);
        wr(32'h00, 32'h4);
        rd_chk("flush_status", 32'h04, 32'h0000_0008);
        rd_chk("flush_ctrl", 32'h00, 32'h0);
        rd_chk("flush_data", 32'h08, 32'h0);
        wr(32'h04, 32'h8);

        // enable cleared mid-line after 3 px
        wr(32'h00, 32'h1);
        frame_start();
        href = 1'b1;
        send_px(16'h41);
        send_px(16'h42);
        send_px(16'h43);
        wr(32'h00, 32'h0);
        rd_chk("abort_state", 32'h10, 32'd0);
        rd_chk("abort_status", 32'h04, 32'h0);
        frame_end();
        rd_chk("abort_status_end", 32'h04, 32'h0);
        rd_chk("abort_frame_cnt", 32'h0C, 32'd5);

        // reset asserted in the middle of a capture
        wr(32'h00, 32'h9);
        frame_start();
        send_line(4, 16'h51);
        frame_end();
        frame_start();
        href = 1'b1;
        send_px(16'h61);
        send_px(16'h62);
        rd_chk("prerst_state", 32'h10, 32'd2);
        check("prerst_irq", {31'd0, irq8}, 32'd1);
        reset = 1'b0;
        wait_clk(3);
        check("inrst_irq", {31'd0, irq8}, 32'd0);
        check("inrst_ack", {31'd0, ack8}, 32'd0);
        reset = 1'b1;
        wait_clk(5);
        run_table(0, 5);
        frame_end();

        // 16-bit instance
        sel16 = 1'b1;
        wr(32'h00, 32'h1);
        frame_start();
        href = 1'b1;
        send_px(16'h1234);
        send_px(16'hABCD);
        frame_end();
        rd_chk("p16_data", 32'h08, 32'hABCD_1234);
        rd_chk("p16_empty", 32'h08, 32'h0);
        rd_chk("p16_status", 32'h04, 32'h0000_0008);
        rd_chk("p16_frame_cnt", 32'h0C, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
